// File: rtl/fpu_wb_buffer.sv
// fpu_wb_buffer: in-order FIFO between the FPU result handshake and FP register write-back, with sticky fflags.
// Optional FPU_WB_BYPASS_EN forwards an input beat straight to the outputs when the buffer is empty.
module fpu_wb_buffer #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 5,
  parameter int DEPTH     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           result_i,
  input  logic [4:0]                 status_i,
  input  logic [TAG_WIDTH-1:0]       tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           result_o,
  output logic [4:0]                 status_o,
  output logic [TAG_WIDTH-1:0]       tag_o,
  output logic [4:0]                 fflags_o,
  input  logic                       fflags_clr_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0]     mem_result [DEPTH];
  logic [4:0]           mem_status [DEPTH];
  logic [TAG_WIDTH-1:0] mem_tag    [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [4:0]           fflags;
  logic                 empty, push, pop, retire;
  always_comb begin
    empty      = count == '0;
    in_ready_o = count < CW'(DEPTH);
`ifdef FPU_WB_BYPASS_EN
    out_valid_o = !empty || in_valid_i;
    result_o    = !empty ? mem_result[rd_ptr] : in_valid_i ? result_i : '0;
    status_o    = !empty ? mem_status[rd_ptr] : in_valid_i ? status_i : '0;
    tag_o       = !empty ? mem_tag[rd_ptr]    : in_valid_i ? tag_i    : '0;
`else
    out_valid_o = !empty;
    result_o    = empty ? '0 : mem_result[rd_ptr];
    status_o    = empty ? '0 : mem_status[rd_ptr];
    tag_o       = empty ? '0 : mem_tag[rd_ptr];
`endif
    retire = out_valid_o && out_ready_i && !flush_i;
    // a retire while empty is a bypassed beat: it never touches storage
    pop  = retire && !empty;
    push = in_valid_i && in_ready_o && !flush_i && !(retire && empty);
  end
  assign busy_o   = !empty;
  assign count_o  = count;
  assign fflags_o = fflags;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fflags <= '0;
    end else begin
      fflags <= (fflags_clr_i ? 5'b0 : fflags) | (retire ? status_o : 5'b0);
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
        count  <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_result[wr_ptr] <= result_i;
      mem_status[wr_ptr] <= status_i;
      mem_tag[wr_ptr]    <= tag_i;
    end
  end
endmodule

// File: tb/tb_fpu_wb_buffer.sv
// tb_fpu_wb_buffer: directed test-plan steps plus random traffic against a queue-based reference model.
module tb_fpu_wb_buffer;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [63:0] r;
    logic [4:0]  s;
    logic [4:0]  t;
  } ent_t;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_ready, out_valid, out_ready = 0, fflags_clr = 0, busy;
  logic [63:0] result_in = '0, result_out;
  logic [4:0]  status_in = '0, status_out, tag_in = '0, tag_out, fflags;
  logic [2:0]  count;
  int          checks = 0, failures = 0;
  ent_t        q[$];
  logic [4:0]  m_ff = '0;
  fpu_wb_buffer #(.WIDTH(64), .TAG_WIDTH(5), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .result_i(result_in), .status_i(status_in), .tag_i(tag_in), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result_out), .status_o(status_out), .tag_o(tag_out),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr), .count_o(count), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Drive one cycle, compare against the model, advance model and clock.
  task automatic cycle(bit v, bit r, bit fl, bit cl, logic [63:0] res, logic [4:0] st, logic [4:0] tg);
    ent_t h;
    bit   do_pop, do_push;
    in_valid = v; out_ready = r; flush = fl; fflags_clr = cl;
    result_in = res; status_in = st; tag_in = tg;
    #1;
    h = q.size() != 0 ? q[0] : '0;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("count", count, q.size());
    chk("busy", busy, q.size() != 0);
    chk("fflags", fflags, m_ff);
    chk("head_result", result_out, h.r);
    chk("head_status", status_out, h.s);
    chk("head_tag", tag_out, h.t);
    do_pop  = !fl && r && q.size() != 0;
    do_push = !fl && v && q.size() < DEPTH;
    m_ff = (cl ? 5'b0 : m_ff) | (do_pop ? h.s : 5'b0);
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{r: res, s: st, t: tg});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_fflags", fflags, 0);
    rst_n = 1;
    cycle(0, 0, 0, 0, 0, 0, 0);
    // fill to full, fifth beat held off, then drain in order
    for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 0, 64'(i * 3), 0, 5'(i));
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    cycle(1, 0, 0, 0, 64'h55, 0, 5);
    for (int i = 1; i <= 4; i++) begin
      chk("pop_order", tag_out, i);
      cycle(0, 1, 0, 0, 0, 0, 0);
    end
    chk("drain_count", count, 0);
    // sticky flags
    cycle(1, 0, 0, 0, 64'h1, 5'b00001, 7);
    cycle(1, 0, 0, 0, 64'h2, 5'b10000, 8);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("ff_accum", fflags, 5'b10001);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("ff_clear", fflags, 5'b00000);
    // clear with simultaneous pop keeps popped status
    cycle(1, 0, 0, 0, 64'h3, 5'b00011, 9);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("ff_pre", fflags, 5'b00011);
    cycle(1, 0, 0, 0, 64'h4, 5'b00100, 10);
    cycle(0, 1, 0, 1, 0, 0, 0);
    chk("ff_clr_pop", fflags, 5'b00100);
    // flush with simultaneous push, fflags survive
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 64'h5, 5'b00010, 11);
    cycle(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 64'(100 + i), 0, 5'(12 + i));
    chk("pre_flush_count", count, 3);
    cycle(1, 0, 1, 0, 64'hdead, 5'b11111, 31);
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_fflags", fflags, 5'b00010);
    cycle(0, 1, 0, 0, 0, 0, 0);
    // continuous push+pop across pointer wrap
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (i > 0) chk("stream_tag", tag_out, i - 1);
      cycle(1, 1, 0, 0, 64'(i), 0, 5'(i));
      chk("stream_count", count, 1);
    end
    cycle(0, 1, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 15) == 0, {$urandom, $urandom}, 5'($urandom), 5'($urandom));
    // asynchronous reset mid-operation
    cycle(1, 0, 0, 0, 64'h77, 5'b01000, 3);
    cycle(1, 0, 0, 0, 64'h78, 5'b01000, 4);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_fflags", fflags, 0);
    q.delete();
    m_ff = '0;
    @(posedge clk);
    #1 rst_n = 1;
    cycle(0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_wb_buffer.md
Name: fpu_wb_buffer

Overview:
- Result write-back buffer directly downstream of the FPU top-level output handshake.
- Accepts result/status/tag beats on a valid/ready interface.
- Stores them in a small in-order FIFO and presents them to the core's FP register-file write port.
- Also accumulates the sticky fflags CSR bits from every retired result, so FPU back-pressure is decoupled from core write-back stalls.

Parameters:
- WIDTH, 64, result datapath width in bits; matches the FPU result width.
- TAG_WIDTH, 5, width of the tag carried with each result (destination register index).
- DEPTH, 4, number of FIFO entries; must be a power of two and >= 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; discards all buffered entries.
- in_valid_i  in  1  FPU output beat valid.
- in_ready_o  out  1  buffer can accept a beat.
- result_i  in  WIDTH  FPU result.
- status_i  in  5  FPU status {NV,DZ,OF,UF,NX}, NV at bit 4.
- tag_i  in  TAG_WIDTH  FPU tag.
- out_valid_o  out  1  head entry valid toward write-back.
- out_ready_i  in  1  write-back accepts the head entry.
- result_o  out  WIDTH  head result.
- status_o  out  5  head status.
- tag_o  out  TAG_WIDTH  head tag.
- fflags_o  out  5  sticky accumulated exception flags.
- fflags_clr_i  in  1  clear fflags (CSR write to fflags/fcsr).
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- busy_o  out  1  high when count_o != 0.

Behaviour:
- Reset (rst_ni low, asynchronous): read/write pointers 0, count 0, fflags 0.
  - Resulting outputs: out_valid_o=0, in_ready_o=1, busy_o=0, count_o=0, fflags_o=0.
  - result_o, status_o and tag_o are 0 while empty.
- Push: in_valid_i && in_ready_o. Entry written at the write pointer, which increments mod DEPTH.
- Pop: out_valid_o && out_ready_i. Read pointer increments mod DEPTH.
- in_ready_o = (count < DEPTH). No combinational path from out_ready_i to in_ready_o.
  - When full, a push is refused even if a pop occurs in the same cycle.
- out_valid_o = (count != 0). Head data is driven from the read-pointer entry, registered storage only.
- Latency: a beat pushed in cycle N is visible on the outputs in cycle N+1 at the earliest.
- Ordering: strictly in-order; tags are not reordered.
- Counter update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged, both pointers advance.
- Once out_valid_o is asserted, head data must stay stable until popped or flushed. No withdrawal.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0. Full/empty are decided by count, not by pointer compare.
- fflags update, per cycle:
  - fflags_clr_i with no pop: fflags_next = 0.
  - fflags_clr_i with a pop in the same cycle: fflags_next = status of the popped entry (the clear applies first, then the OR).
  - Otherwise: fflags_next = fflags | (pop ? status_o : 0).
- Flush (flush_i=1):
  - Next cycle: count=0, both pointers=0, out_valid_o=0.
  - A push or pop in the flush cycle is discarded and does not affect fflags.
  - fflags itself is NOT cleared by flush.
  - in_ready_o is not gated by flush_i.
- Reset mid-operation: all state returns to reset values immediately. In-flight entries are lost.

Optional Feature:
- Macro: FPU_WB_BYPASS_EN.
- Defined: when count==0 and in_valid_i=1, the input beat is forwarded combinationally to result_o/status_o/tag_o with out_valid_o=1.
  - If out_ready_i=1 in that cycle, the beat is retired without being written. Pointers and count are unchanged, and fflags ORs status_i.
  - Otherwise the beat is written normally.
  - Zero-cycle latency when empty.
- Not defined: no input-to-output combinational path; minimum latency is one cycle as specified above.

Test Plan:
- Reset then idle -> out_valid_o=0, in_ready_o=1, count_o=0, fflags_o=5'b00000.
- Push tags 1,2,3,4 with out_ready_i=0 -> count_o=4, in_ready_o=0. A fifth beat (tag 5) is held off. Then out_ready_i=1 pops tags 1,2,3,4 in order, count_o returns to 0.
- Push status 5'b00001 (NX) then 5'b10000 (NV), pop both -> fflags_o=5'b10001. Assert fflags_clr_i alone -> 5'b00000.
- fflags_clr_i asserted in the same cycle as a pop of status 5'b00100 (OF), prior fflags 5'b00011 -> fflags_o=5'b00100.
- Three entries buffered, fflags=5'b00010, assert flush_i with simultaneous in_valid_i -> next cycle count_o=0, out_valid_o=0, fflags_o=5'b00010. The flush-cycle beat is never output.
- Continuous push+pop every cycle for 3*DEPTH beats (tags 0..11) -> count_o constant at 1 after the first cycle, tags emerge in order across pointer wrap.
  - With FPU_WB_BYPASS_EN, the same stimulus started from empty gives count_o=0 throughout, with 0-cycle latency.
